// File: rtl/dma_wb_writer.sv
// dma_wb_writer: buffers accelerator result words in a small FIFO and writes
// them to DRAM as single-beat Wishbone cycles over a CPU-programmed byte range.
module dma_wb_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cpu_wbs_stb_i,
    input  logic                  cpu_wbs_cyc_i,
    input  logic                  cpu_wbs_we_i,
    input  logic [3:0]            cpu_wbs_sel_i,
    input  logic [31:0]           cpu_wbs_adr_i,
    input  logic [31:0]           cpu_wbs_dat_i,
    input  logic                  acc_res_valid_i,
    input  logic [DATA_WIDTH-1:0] acc_res_data_i,
    output logic                  acc_res_ready_o,
    output logic                  dram_wbs_stb_i,
    output logic                  dram_wbs_cyc_i,
    output logic                  dram_wbs_we_i,
    output logic [3:0]            dram_wbs_sel_i,
    output logic [31:0]           dram_wbs_adr_i,
    output logic [DATA_WIDTH-1:0] dram_wbs_dat_i,
    input  logic                  dram_wbs_ack_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cmd_err_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;
    state_t                state_q;
    logic [7:0]            cur_addr_q, end_addr_q;
    logic [6:0]            total_q, accepted_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [AW:0]           count_q;
    logic                  err_q;
    logic                  cmd, full, empty, push, pop, wr;
    logic [7:0]            base_d, end_d, span;
    logic                  unused_ok;
    assign unused_ok = ^{cpu_wbs_sel_i, cpu_wbs_adr_i[15:0], cpu_wbs_dat_i[31:16]};
    assign cmd    = cpu_wbs_cyc_i & cpu_wbs_stb_i & cpu_wbs_we_i & (cpu_wbs_adr_i[31:16] == 16'h3601);
    assign base_d = cpu_wbs_dat_i[15:8] & 8'hFC;
    assign end_d  = cpu_wbs_dat_i[7:0] & 8'hFC;
    assign span   = end_d - base_d;
    assign full   = count_q == (AW+1)'(DEPTH);
    assign empty  = count_q == '0;
    assign wr     = state_q == WRITE;
    assign acc_res_ready_o = (state_q == WAIT || wr) && !full && (accepted_q < total_q);
    assign push   = acc_res_valid_i & acc_res_ready_o;
    assign pop    = wr & dram_wbs_ack_o;
    // Bus outputs decode straight from the state register so an async reset drops them at once
    assign dram_wbs_stb_i = wr;
    assign dram_wbs_cyc_i = wr;
    assign dram_wbs_we_i  = wr;
    assign dram_wbs_sel_i = {4{wr}};
    assign dram_wbs_adr_i = wr ? {10'h1E0, 12'd0, 2'd3, cur_addr_q} : '0;
    assign dram_wbs_dat_i = wr ? mem_q[rd_ptr_q] : '0;
    assign busy_o    = state_q != IDLE;
    assign done_o    = state_q == DONE;
    assign cmd_err_o = err_q;

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= acc_res_data_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            total_q    <= '0;
            accepted_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q   <= cmd && state_q != IDLE;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                accepted_q <= accepted_q + 7'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case (state_q)
                IDLE: if (cmd) begin
                    cur_addr_q <= base_d;
                    end_addr_q <= end_d;
                    total_q    <= {1'b0, span[7:2]} + 7'd1;
                    accepted_q <= '0;
                    state_q    <= WAIT;
                end
                WAIT: if (!empty) state_q <= WRITE;
                WRITE: if (dram_wbs_ack_o) begin
                    cur_addr_q <= cur_addr_q + 8'd4;
                    state_q    <= (cur_addr_q == end_addr_q) ? DONE : WAIT;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_wb_writer.sv
// tb_dma_wb_writer: directed stimulus with a queue-based transfer model that
// checks every cycle, plus literal expectations for each scenario.
module tb_dma_wb_writer;
    localparam int DEPTH = 4;
    logic        clk, rst;
    logic        cstb, ccyc, cwe;
    logic [31:0] cadr, cdat;
    logic        valid, ready;
    logic [31:0] data;
    logic        stb, cyc, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat;
    logic        busy, done, err;

    int tests = 0, fails = 0;

    dma_wb_writer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cpu_wbs_stb_i(cstb), .cpu_wbs_cyc_i(ccyc), .cpu_wbs_we_i(cwe),
        .cpu_wbs_sel_i(4'hF), .cpu_wbs_adr_i(cadr), .cpu_wbs_dat_i(cdat),
        .acc_res_valid_i(valid), .acc_res_data_i(data), .acc_res_ready_o(ready),
        .dram_wbs_stb_i(stb), .dram_wbs_cyc_i(cyc), .dram_wbs_we_i(we),
        .dram_wbs_sel_i(sel), .dram_wbs_adr_i(adr), .dram_wbs_dat_i(dat),
        .dram_wbs_ack_o(ack),
        .busy_o(busy), .done_o(done), .cmd_err_o(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Transfer model: range, accepted-word queue, counts of accepted/written words
    logic        active = 0, done_exp = 0, err_exp = 0, ack_prev = 0;
    logic [7:0]  base_m = 0, end_m = 0;
    int          total_m = 0, acc_m = 0, wr_m = 0;
    logic [31:0] mq[$];
    logic [31:0] wadr[$], wdat[$];
    int          done_cnt = 0, err_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out", nm);
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            active = 0; done_exp = 0; err_exp = 0; ack_prev = 0;
            acc_m = 0; wr_m = 0; mq.delete();
        end else begin
            logic fin, cmd_in;
            fin = done_exp;
            cmd_in = ccyc && cstb && cwe && cadr[31:16] == 16'h3601;
            err_exp = cmd_in && active;
            if (cmd_in && !active) begin
                active = 1;
                base_m = cdat[15:8] & 8'hFC;
                end_m = cdat[7:0] & 8'hFC;
                total_m = ((int'(end_m) - int'(base_m)) & 255) / 4 + 1;
                acc_m = 0;
                wr_m = 0;
            end
            if (valid && ready) begin
                mq.push_back(data);
                acc_m++;
            end
            done_exp = 0;
            ack_prev = ack && stb;
            if (ack && stb) begin
                wadr.push_back(adr);
                wdat.push_back(dat);
                if (mq.size() > 0) void'(mq.pop_front());
                wr_m++;
                done_exp = (wr_m == total_m);
            end
            if (fin) active = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            chk("busy", busy, active);
            chk("done", done, done_exp);
            chk("cmd_err", err, err_exp);
            chk("ready_legal", ready && !(active && !done_exp && acc_m < total_m && acc_m - wr_m < DEPTH), 0);
            chk("stb_legal", stb && !(active && !done_exp && !ack_prev && mq.size() > 0), 0);
            if (stb) begin
                chk("adr", adr, {24'h780003, 8'(int'(base_m) + 4 * wr_m)});
                chk("dat", dat, mq.size() > 0 ? mq[0] : 32'hx);
                chk("quals", {cyc, we, sel}, 6'h3F);
            end else chk("idle_bus", {cyc, we, sel, |adr, |dat}, 0);
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(posedge clk); #1;
        ccyc = 1; cstb = 1; cwe = w; cadr = a; cdat = d;
        @(posedge clk); #1;
        ccyc = 0; cstb = 0; cwe = 0;
    endtask

    task automatic send(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            valid = 1;
            data = first + i;
            do begin @(negedge clk); t++; end while (!ready && t < 300);
            if (!ready) timeout("send");
            @(posedge clk); #1;
        end
        valid = 0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 300) begin @(negedge clk); t++; end
        if (!done) timeout(nm);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_w(input string nm, input int i, input logic [31:0] ea, input logic [31:0] ed);
        chk({nm, "_adr"}, wadr.size() > i ? wadr[i] : 32'hx, ea);
        chk({nm, "_dat"}, wdat.size() > i ? wdat[i] : 32'hx, ed);
    endtask

    task automatic clear_rec();
        wadr.delete(); wdat.delete(); done_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; cstb = 0; ccyc = 0; cwe = 0; cadr = 0; cdat = 0;
        valid = 0; data = 0; ack = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ready, 0);
        chk("rst_stb", {stb, cyc, we, sel}, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);

        // Basic range 0x00..0x10
        clear_rec();
        ack = 1;
        cpu_write(32'h36010000, 32'h00000010, 1);
        send(32'hA0, 5);
        chk("basic_ready_after_5", ready, 0);
        wait_done("basic_done");
        chk("basic_n", wadr.size(), 5);
        chk_w("basic0", 0, 32'h78000300, 32'hA0);
        chk_w("basic1", 1, 32'h78000304, 32'hA1);
        chk_w("basic2", 2, 32'h78000308, 32'hA2);
        chk_w("basic3", 3, 32'h7800030C, 32'hA3);
        chk_w("basic4", 4, 32'h78000310, 32'hA4);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_idle", busy, 0);

        // Wrap-around range 0xF8..0x04
        clear_rec();
        cpu_write(32'h36010000, 32'h0000F804, 1);
        send(32'hD0, 4);
        wait_done("wrap_done");
        chk("wrap_n", wadr.size(), 4);
        chk_w("wrap0", 0, 32'h780003F8, 32'hD0);
        chk_w("wrap1", 1, 32'h780003FC, 32'hD1);
        chk_w("wrap2", 2, 32'h78000300, 32'hD2);
        chk_w("wrap3", 3, 32'h78000304, 32'hD3);
        chk("wrap_done_cnt", done_cnt, 1);

        // Backpressure: first beat stalled 20 cycles while valid stays high
        clear_rec();
        ack = 0;
        cpu_write(32'h36010000, 32'h0000001C, 1);
        fork send(32'hC0, 8); join_none
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("bp_accepted", acc_m, 4);
        chk("bp_ready_full", ready, 0);
        chk("bp_stb_held", stb, 1);
        @(posedge clk); #1 ack = 1;
        wait_done("bp_done");
        chk("bp_n", wadr.size(), 8);
        for (int i = 0; i < 8; i++) chk_w("bp", i, 32'h78000300 + 4 * i, 32'hC0 + i);

        // Second command while busy
        clear_rec();
        cpu_write(32'h36010000, 32'h00000008, 1);
        cpu_write(32'h36010000, 32'h00000040, 1);
        send(32'h50, 3);
        wait_done("busy_done");
        chk("busy_err_cnt", err_cnt, 1);
        chk("busy_n", wadr.size(), 3);
        chk_w("busy0", 0, 32'h78000300, 32'h50);
        chk_w("busy2", 2, 32'h78000308, 32'h52);

        // Non-matching address and CPU read
        clear_rec();
        cpu_write(32'h36000000, 32'h00000010, 1);
        @(negedge clk);
        chk("nomatch_busy", busy, 0);
        cpu_write(32'h36010000, 32'h00000010, 0);
        @(negedge clk);
        chk("read_busy", busy, 0);

        // Async reset during WRITE
        clear_rec();
        ack = 0;
        cpu_write(32'h36010000, 32'h00000004, 1);
        send(32'hE0, 1);
        begin
            int t = 0;
            while (!stb && t < 50) begin @(negedge clk); t++; end
            if (!stb) timeout("rst_wait_stb");
        end
        #1 rst = 1;
        #1 chk("async_drop", {stb, cyc, we}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        ack = 1;
        cpu_write(32'h36010000, 32'h00002024, 1);
        send(32'hB0, 2);
        wait_done("post_rst_done");
        chk("post_rst_n", wadr.size(), 2);
        chk_w("post_rst0", 0, 32'h78000320, 32'hB0);
        chk_w("post_rst1", 1, 32'h78000324, 32'hB1);
        chk("post_rst_done_cnt", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
